// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between speculative loads and committed stores (queued in a small FIFO).
// Each access is a req/ack handshake; every issued access is announced to the load buffer.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 32,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exception,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [TAG_W-1:0]  ld_inst_num,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [TAG_W-1:0]  st_inst_num,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_done_data,
  output logic [TAG_W-1:0]  ld_done_inst_num,
  output logic              lb_memread,
  output logic [ADDR_W-1:0] lb_load_addr,
  output logic [TAG_W-1:0]  lb_load_inst_num,
  output logic              lb_memwrite,
  output logic [ADDR_W-1:0] lb_store_addr,
  output logic [TAG_W-1:0]  lb_store_inst_num
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(QDEPTH);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LD_REQ, ST_REQ, LD_FLUSH} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  inst_num;
  } st_entry_t;

  state_e            state_q;
  st_entry_t         fifo_mem [QDEPTH];
  st_entry_t         head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              fifo_empty, fifo_full, st_push, st_grant, ld_grant;

  logic              mem_req_q, mem_we_q, ld_done_q, lb_memread_q, lb_memwrite_q;
  logic [ADDR_W-1:0] mem_addr_q, lb_load_addr_q, lb_store_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, ld_done_data_q;
  logic [TAG_W-1:0]  ld_done_inst_q, lb_load_inst_q, lb_store_inst_q;

  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    st_push    = st_valid && !fifo_full;
    st_grant   = (state_q == IDLE) && !fifo_empty &&
                 (!ld_valid || fifo_full || (starve_q >= STARVE_LIM));
    ld_grant   = (state_q == IDLE) && !st_grant && ld_valid && !exception;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (st_push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (st_grant) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({st_push, st_grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (ld_grant && !fifo_empty && (starve_q < STARVE_LIM)) starve_d = starve_q + 1'b1;
    if (st_grant || exception || fifo_empty) starve_d = '0;
  end

  // Readies are forced low while reset is held so every output reads 0 during reset.
  assign ld_ready = reset && ld_grant;
  assign st_ready = reset && !fifo_full;

  // NOTE: FIFO storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (st_push) fifo_mem[wr_ptr_q] <= '{addr: st_addr, data: st_data, inst_num: st_inst_num};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      ld_done_q       <= 1'b0;
      ld_done_data_q  <= '0;
      ld_done_inst_q  <= '0;
      lb_memread_q    <= 1'b0;
      lb_load_addr_q  <= '0;
      lb_load_inst_q  <= '0;
      lb_memwrite_q   <= 1'b0;
      lb_store_addr_q <= '0;
      lb_store_inst_q <= '0;
    end else begin
      lb_memread_q  <= 1'b0;
      lb_memwrite_q <= 1'b0;
      ld_done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (st_grant) begin
            state_q         <= ST_REQ;
            mem_req_q       <= 1'b1;
            mem_we_q        <= 1'b1;
            mem_addr_q      <= head.addr;
            mem_wdata_q     <= head.data;
            lb_memwrite_q   <= 1'b1;
            lb_store_addr_q <= head.addr;
            lb_store_inst_q <= head.inst_num;
          end else if (ld_grant) begin
            state_q        <= LD_REQ;
            mem_req_q      <= 1'b1;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= ld_addr;
            mem_wdata_q    <= '0;
            lb_memread_q   <= 1'b1;
            lb_load_addr_q <= ld_addr;
            lb_load_inst_q <= ld_inst_num;
          end
        end
        LD_REQ: begin
          // The in-flight load's tag is still held in lb_load_inst_q (no other load can issue).
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (!exception) begin
              ld_done_q      <= 1'b1;
              ld_done_data_q <= mem_rdata;
              ld_done_inst_q <= lb_load_inst_q;
            end
          end else if (exception) begin
            state_q <= LD_FLUSH;
          end
        end
        ST_REQ, LD_FLUSH: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign ld_done           = ld_done_q;
  assign ld_done_data      = ld_done_data_q;
  assign ld_done_inst_num  = ld_done_inst_q;
  assign lb_memread        = lb_memread_q;
  assign lb_load_addr      = lb_load_addr_q;
  assign lb_load_inst_num  = lb_load_inst_q;
  assign lb_memwrite       = lb_memwrite_q;
  assign lb_store_addr     = lb_store_addr_q;
  assign lb_store_inst_num = lb_store_inst_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked cycle by cycle
// against a queue-based transaction model of the port.
module tb_mem_port_arbiter;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exception = 1'b0;
  logic        ld_valid = 1'b0, st_valid = 1'b0, mem_ack = 1'b0;
  logic [31:0] ld_addr = '0, ld_inst_num = '0, st_addr = '0, st_data = '0, st_inst_num = '0;
  logic [31:0] mem_rdata = '0;
  logic        ld_ready, st_ready, mem_req, mem_we, ld_done, lb_memread, lb_memwrite;
  logic [31:0] mem_addr, mem_wdata, ld_done_data, ld_done_inst_num;
  logic [31:0] lb_load_addr, lb_load_inst_num, lb_store_addr, lb_store_inst_num;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TAG_W(32), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .exception(exception),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_inst_num(ld_inst_num),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_inst_num(st_inst_num),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_done(ld_done), .ld_done_data(ld_done_data), .ld_done_inst_num(ld_done_inst_num),
    .lb_memread(lb_memread), .lb_load_addr(lb_load_addr), .lb_load_inst_num(lb_load_inst_num),
    .lb_memwrite(lb_memwrite), .lb_store_addr(lb_store_addr), .lb_store_inst_num(lb_store_inst_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] tag;
  } st_t;

  // Transaction model: pending stores, what the port is doing, how many loads have jumped a store.
  st_t         mq[$];
  int          m_busy;       // 0 free, 1 load, 2 store
  bit          m_flush;
  int          m_starve;
  logic        e_req, e_we, e_done, e_rd, e_wr;
  logic [31:0] e_addr, e_wdata, e_done_data, e_done_tag;
  logic [31:0] e_ld_addr, e_ld_tag, e_st_addr, e_st_tag;

  int          n_tests = 0, n_fail = 0, n_rd = 0;
  logic [31:0] wr_log[$];
  logic [31:0] exp_addrs[5];
  bit          seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_flush = 0; m_starve = 0;
    e_req = 0; e_we = 0; e_done = 0; e_rd = 0; e_wr = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_ld_done"}, ld_done, 0);
    check({tag, "_lb_memread"}, lb_memread, 0);
    check({tag, "_lb_memwrite"}, lb_memwrite, 0);
    check({tag, "_lb_store_addr"}, lb_store_addr, 0);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_st_ready"}, st_ready, 0);
  endtask

  // One clock: inputs were set just after the previous edge; check readies, advance, check outputs.
  task automatic cycle();
    bit  full, empty, st_win, ld_win;
    st_t ent;
    #2;
    full   = (mq.size() == QDEPTH);
    empty  = (mq.size() == 0);
    st_win = (m_busy == 0) && !empty && (!ld_valid || full || m_starve >= STARVE_MAX);
    ld_win = (m_busy == 0) && !st_win && ld_valid && !exception;
    check("ld_ready", ld_ready, ld_win);
    check("st_ready", st_ready, !full);
    e_rd = 0; e_wr = 0; e_done = 0;
    if (m_busy == 0) begin
      if (st_win) begin
        ent = mq.pop_front();
        m_busy = 2; e_req = 1; e_we = 1; e_addr = ent.addr; e_wdata = ent.data;
        e_wr = 1; e_st_addr = ent.addr; e_st_tag = ent.tag;
      end else if (ld_win) begin
        m_busy = 1; e_req = 1; e_we = 0; e_addr = ld_addr;
        e_rd = 1; e_ld_addr = ld_addr; e_ld_tag = ld_inst_num;
      end
    end else if (mem_ack) begin
      if (m_busy == 1 && !m_flush && !exception) begin
        e_done = 1; e_done_data = mem_rdata; e_done_tag = e_ld_tag;
      end
      m_busy = 0; m_flush = 0; e_req = 0;
    end else if (m_busy == 1 && exception) begin
      m_flush = 1;
    end
    if (ld_win && !empty) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    if (st_win || exception || empty) m_starve = 0;
    if (st_valid && !full) mq.push_back('{st_addr, st_data, st_inst_num});
    @(posedge clk);
    #1;
    check("mem_req", mem_req, e_req);
    if (e_req) begin
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
    end
    check("ld_done", ld_done, e_done);
    if (e_done) begin
      check("ld_done_data", ld_done_data, e_done_data);
      check("ld_done_inst_num", ld_done_inst_num, e_done_tag);
    end
    check("lb_memread", lb_memread, e_rd);
    if (e_rd) begin
      check("lb_load_addr", lb_load_addr, e_ld_addr);
      check("lb_load_inst_num", lb_load_inst_num, e_ld_tag);
    end
    check("lb_memwrite", lb_memwrite, e_wr);
    if (e_wr) begin
      check("lb_store_addr", lb_store_addr, e_st_addr);
      check("lb_store_inst_num", lb_store_inst_num, e_st_tag);
    end
    if (lb_memwrite) wr_log.push_back(lb_store_addr);
    if (lb_memread) n_rd++;
  endtask

  task automatic settle();
    ld_valid = 0; st_valid = 0; exception = 0; mem_ack = 1;
    repeat (14) cycle();
    mem_ack = 0;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] t);
    st_valid = 1; st_addr = a; st_data = d; st_inst_num = t;
    cycle();
    st_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    reset = 1;

    // Single load, ack on the first request cycle.
    ld_valid = 1; ld_addr = 32'h100; ld_inst_num = 5;
    #1;
    check("t1_ld_ready", ld_ready, 1);
    cycle();
    check("t1_mem_req", mem_req, 1);
    check("t1_lb_memread", lb_memread, 1);
    check("t1_lb_load_addr", lb_load_addr, 32'h100);
    ld_valid = 0; mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    cycle();
    check("t1_ld_done", ld_done, 1);
    check("t1_ld_done_tag", ld_done_inst_num, 5);
    check("t1_ld_done_data", ld_done_data, 32'hCAFE_F00D);
    settle();

    // Five stores with memory stalled: one goes out, four fill the FIFO.
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      exp_addrs[i] = 32'h2000 + 32'(i * 16);
      push_store(exp_addrs[i], 32'hD000 + 32'(i), 32'(20 + i));
    end
    check("t2_st_ready_full", st_ready, 0);
    settle();
    check("t2_store_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) check("t2_store_order", wr_log[i], exp_addrs[i]);

    // Starvation limit: a waiting store lets exactly STARVE_MAX loads pass, twice.
    ld_valid = 1; ld_addr = 32'h500; ld_inst_num = 50; mem_ack = 1;
    cycle();
    for (int r = 0; r < 2; r++) begin
      push_store(32'h3000 + 32'(r), 32'h3300 + 32'(r), 32'(60 + r));
      n_rd = 0; seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        ld_addr = $urandom; ld_inst_num = 32'(100 + i);
        cycle();
        if (lb_memwrite) seen = 1;
      end
      check("t3_store_granted", seen, 1);
      check("t3_loads_before_store", n_rd, STARVE_MAX);
    end
    settle();

    // Exception while a load waits three cycles for its ack.
    ld_valid = 1; ld_addr = 32'h400; ld_inst_num = 9; mem_ack = 0;
    cycle();
    exception = 1;
    cycle();
    check("t4_req_held0", mem_req, 1);
    exception = 0; ld_valid = 0;
    cycle();
    check("t4_req_held1", mem_req, 1);
    cycle();
    check("t4_req_held2", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    cycle();
    check("t4_no_ld_done", ld_done, 0);
    check("t4_req_dropped", mem_req, 0);
    mem_ack = 0; exception = 1; ld_valid = 1; ld_addr = 32'h440;
    #1;
    check("t4_ld_ready_exc", ld_ready, 0);
    cycle();
    check("t4_no_issue_exc", lb_memread, 0);
    settle();

    // Enqueue and dequeue in the same cycle at count 2.
    wr_log.delete();
    ld_valid = 1; ld_addr = 32'h600; ld_inst_num = 70;
    cycle();
    ld_valid = 0;
    for (int i = 0; i < 5; i++) exp_addrs[i] = 32'h7000 + 32'(i * 4);
    push_store(exp_addrs[0], 32'hA0, 80);
    push_store(exp_addrs[1], 32'hA1, 81);
    mem_ack = 1;
    cycle();
    mem_ack = 0;
    push_store(exp_addrs[2], 32'hA2, 82);
    check("t6_pop_push_issue", lb_memwrite, 1);
    push_store(exp_addrs[3], 32'hA3, 83);
    check("t6_not_full_at3", st_ready, 1);
    push_store(exp_addrs[4], 32'hA4, 84);
    check("t6_full_at4", st_ready, 0);
    settle();
    check("t6_store_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) check("t6_store_order", wr_log[i], exp_addrs[i]);

    // Asynchronous reset in the middle of a store access.
    push_store(32'h8000, 32'hB0, 90);
    push_store(32'h8004, 32'hB1, 91);
    check("t5_in_store", mem_req, 1);
    reset = 0;
    #1;
    reset_checks("t5_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    cycle();
    cycle();
    check("t5_fifo_empty_no_req", mem_req, 0);
    check("t5_st_ready", st_ready, 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ld_valid    = ($urandom_range(0, 99) < 60);
      ld_addr     = $urandom;
      ld_inst_num = 32'(1000 + i);
      st_valid    = ($urandom_range(0, 99) < 35);
      st_addr     = $urandom;
      st_data     = $urandom;
      st_inst_num = $urandom;
      mem_ack     = ($urandom_range(0, 99) < 45);
      mem_rdata   = $urandom;
      exception   = ($urandom_range(0, 99) < 5);
      cycle();
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
